// File: rtl/sw_axi_lite_regs.sv
// rtl/sw_axi_lite_regs.sv - AXI4-Lite slave register bank (optional SW_AXI_REGS_WR_COUNT_EN: last reg counts writes)
module sw_axi_lite_regs #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   reg_q
);
    localparam int IDXW = ADDR_WIDTH - 2;
`ifdef SW_AXI_REGS_WR_COUNT_EN
    localparam bit LAST_IS_COUNTER = 1'b1;
`else
    localparam bit LAST_IS_COUNTER = 1'b0;
`endif

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_RESP } r_state_e;

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDXW-1:0]  aw_idx_q, aw_idx_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             awready_q, awready_d, wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      regs_q [NUM_REGS];
    logic [31:0]      regs_d [NUM_REGS];
    logic             wr_in_range;
    logic [IDXW-1:0]  rd_idx;
    logic [31:0]      rd_sel;
    logic             unused_addr_bits;

    // Byte-offset bits of the addresses play no part in decode.
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    // State and register bank update; reset drops any pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    // Write path: latch AW and W independently, commit once both are present.
    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        aw_idx_d    = aw_idx_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        regs_d      = regs_q;
        wr_in_range = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_in_range = (32'(aw_idx_d) < NUM_REGS);
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_in_range && aw_idx_d == IDXW'(i)
                            && !(LAST_IS_COUNTER && i == NUM_REGS - 1)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (w_strb_d[b]) regs_d[i][8*b +: 8] = w_data_d[8*b +: 8];
                            end
                        end
                    end
`ifdef SW_AXI_REGS_WR_COUNT_EN
                    if (wr_in_range) regs_d[NUM_REGS-1] = regs_q[NUM_REGS-1] + 32'd1;
`endif
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range ? 2'b00 : 2'b10;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // Read path: sample the addressed register on AR handshake, hold until accepted.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_idx    = araddr[ADDR_WIDTH-1:2];
        rd_sel    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDXW'(i)) rd_sel = regs_q[i];
        end
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    if (32'(rd_idx) < NUM_REGS) begin
                        rdata_d = rd_sel;
                        rresp_d = 2'b00;
                    end else begin
                        rdata_d = '0;
                        rresp_d = 2'b10;
                    end
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    // Flatten the register bank onto reg_q.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs_q[i];
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
endmodule

// File: tb/tb_sw_axi_lite_regs.sv
// tb/tb_sw_axi_lite_regs.sv - self-checking bench for sw_axi_lite_regs
module tb_sw_axi_lite_regs;
    localparam int NR = 16;
`ifdef SW_AXI_REGS_WR_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [11:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*32-1:0] reg_q;

    int errors = 0;
    int checks = 0;
    logic [31:0] m [NR];

    sw_axi_lite_regs #(.ADDR_WIDTH(12), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] packed_model();
        logic [511:0] v = '0;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = m[i];
        return v;
    endfunction

    task automatic model_clear;
        for (int i = 0; i < NR; i++) m[i] = 32'h0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int idx = int'(a[11:2]);
        if (idx >= NR) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            if (!(CNT && idx == NR - 1))
                for (int b = 0; b < 4; b++) if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
            if (CNT) m[NR-1] = m[NR-1] + 32'd1;
        end
    endtask

    task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx = int'(a[11:2]);
        if (idx >= NR) begin d = 32'h0; resp = 2'b10; end
        else begin d = m[idx]; resp = 2'b00; end
    endtask

    // Drives AW after awd cycles and W after wd cycles; checks B timing and payload.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd);
        bit aw_done = 0, w_done = 0, early = 0, aw_f, w_f;
        int cyc = 0;
        logic [1:0] er;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && cyc >= awd;
            wvalid  = !w_done && cyc >= wd;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            tick;
            if (aw_f) aw_done = 1;
            if (w_f) w_done = 1;
            cyc++;
            if (!(aw_done && w_done) && bvalid) early = 1;
        end
        awvalid = 0; wvalid = 0;
        model_write(a, d, s, er);
        chk("wr_handshake_done", aw_done && w_done, 1);
        chk("wr_no_early_b", early, 0);
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, er);
        chk("wr_reg_q", reg_q, packed_model());
        if (bready) begin
            tick;
            chk("wr_bvalid_drop", bvalid, 0);
        end
    endtask

    task automatic do_read(input logic [11:0] a, input int ard,
                           output logic [31:0] ed, output logic [1:0] er);
        bit fired = 0;
        int cyc = 0;
        ed = 32'h0; er = 2'b00;
        araddr = a;
        while (!fired && cyc < 40) begin
            arvalid = cyc >= ard;
            if (arvalid && arready) begin
                fired = 1;
                model_read(a, ed, er);
            end
            tick;
            cyc++;
        end
        arvalid = 0;
        chk("rd_handshake_done", fired, 1);
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, ed);
        chk("rd_rresp", rresp, er);
        if (rready) begin
            tick;
            chk("rd_rvalid_drop", rvalid, 0);
        end
    endtask

    initial begin
        logic [31:0] ed, ed2;
        logic [1:0] er, ewr;
        logic [9:0] ridx;
        model_clear();
        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
        araddr = 0; arvalid = 0; rready = 1;
        repeat (3) tick;
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid, bresp, rresp}, 6'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_reg_q", reg_q, 512'h0);
        rst = 0;
        tick;
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);

        // Write then read
        do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0);
        do_read(12'h004, 0, ed, er);
        chk("reg1_value", reg_q[63:32], 32'hDEADBEEF);

        // Split, partial write: W three cycles ahead of AW
        do_write(12'h008, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_write(12'h008, 32'h11223344, 4'h5, 3, 0);
        chk("reg2_partial", reg_q[95:64], 32'hFF22FF44);
        tick;
        chk("single_b", bvalid, 0);

        // Out of range
        do_write(12'h040, 32'h12345678, 4'hF, 0, 1);
        do_read(12'h040, 0, ed, er);

        // Zero strobe in range
        do_write(12'h004, 32'h0, 4'h0, 1, 0);

        // Backpressure on both channels, second AR during the stall
        bready = 0; rready = 0;
        do_write(12'h014, 32'hA5A5_5A5A, 4'hF, 0, 0);
        do_read(12'h004, 0, ed, er);
        araddr = 12'h014; arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_bvalid", {bvalid, bresp}, 3'b100);
            chk("bp_r", {rvalid, rresp, rdata}, {1'b1, er, ed});
            chk("bp_ready", {awready, wready, arready}, 3'b000);
        end
        rready = 1;
        tick;
        chk("bp_r_accept", {rvalid, arready}, 2'b01);
        model_read(12'h014, ed2, er);
        tick;
        arvalid = 0;
        chk("bp_ar2", {rvalid, rresp, rdata}, {1'b1, er, ed2});
        tick;
        chk("bp_ar2_drop", rvalid, 0);
        bready = 1;
        tick;
        chk("bp_b_drop", bvalid, 0);

        // Same-edge read and write of register 3
        do_write(12'h00C, 32'h1, 4'hF, 0, 0);
        awaddr = 12'h00C; wdata = 32'h2; wstrb = 4'hF; araddr = 12'h00C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        model_read(12'h00C, ed, er);
        model_write(12'h00C, 32'h2, 4'hF, ewr);
        tick;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("rw_rdata_old", {rvalid, rdata}, {1'b1, ed});
        chk("rw_b", {bvalid, bresp}, {1'b1, ewr});
        chk("rw_reg_q", reg_q, packed_model());
        tick;
        chk("rw_drop", {bvalid, rvalid}, 2'b00);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            ridx = 10'($urandom_range(0, 19));
            if ($urandom_range(0, 1) == 1)
                do_write({ridx, 2'($urandom)}, $urandom, 4'($urandom),
                         $urandom_range(0, 2), $urandom_range(0, 2));
            else
                do_read({ridx, 2'($urandom)}, $urandom_range(0, 2), ed, er);
        end

        // Reset with AW held and W absent, after three more writes
        for (int i = 0; i < 3; i++) do_write(12'(4 * i), $urandom, 4'hF, 0, 0);
        awaddr = 12'h010; awvalid = 1;
        tick;
        awvalid = 0;
        chk("aw_only_ready", {awready, wready, bvalid}, 3'b010);
        rst = 1;
        tick;
        model_clear();
        chk("mid_rst_state", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        chk("mid_rst_reg_q", reg_q, 512'h0);
        tick;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_no_b", bvalid, 0);
        end
        chk("post_rst_ready2", {awready, wready, arready}, 3'b111);
        do_write(12'h010, 32'hCAFE0001, 4'hF, 0, 0);
        do_read(12'h03C, 0, ed, er);
        chk("count_after_rst", rdata, CNT ? 32'h1 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
